// File: rtl/flag_stack_unit.sv
// Zero/negative condition flags derived from the ALU result, with a small
// LIFO that saves {z,n} on call and restores it on return.
module flag_stack_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic                  flagWrite,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clearErr,
  output logic                  z,
  output logic                  n,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflowErr,
  output logic                  underflowErr
);

  logic               z_q, z_d;
  logic               n_q, n_d;
  logic [PTR_WIDTH:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [1:0]         stack_q [DEPTH];

  logic                 full_c, empty_c;
  logic                 do_push, do_pop, ovf_evt, unf_evt;
  logic [PTR_WIDTH-1:0] wr_idx, top_idx;

  assign full_c  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign empty_c = (count_q == '0);

  // push and pop together cancel out; only a lone push/pop moves the stack
  assign do_push = push & ~pop & ~full_c;
  assign do_pop  = pop & ~push & ~empty_c;
  assign ovf_evt = push & ~pop & full_c;
  assign unf_evt = pop & ~push & empty_c;

  assign wr_idx  = count_q[PTR_WIDTH-1:0];
  assign top_idx = count_q[PTR_WIDTH-1:0] - PTR_WIDTH'(1);

  always_comb begin
    z_d     = z_q;
    n_d     = n_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // restored flags take priority over a same-cycle flag write
    if (do_pop) begin
      z_d = stack_q[top_idx][1];
      n_d = stack_q[top_idx][0];
    end else if (flagWrite) begin
      z_d = (aluResult == '0);
      n_d = aluResult[DATA_WIDTH-1];
    end

    if (do_push) begin
      count_d = count_q + 1'b1;
    end else if (do_pop) begin
      count_d = count_q - 1'b1;
    end

    // a new error event beats a same-cycle clear
    if (clearErr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (unf_evt) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      z_q     <= z_d;
      n_q     <= n_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so entries carry no reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_idx == PTR_WIDTH'(gi))) begin
        stack_q[gi] <= {z_q, n_q};
      end
    end
  end

  assign z            = z_q;
  assign n            = n_q;
  assign count        = count_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;

endmodule

// File: tb/tb_flag_stack_unit.sv
// Directed, table-driven check of flag_stack_unit plus an async-reset sequence.
module tb_flag_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] aluResult;
  logic        flagWrite, push, pop, clearErr;
  logic        z, n, full, empty, overflowErr, underflowErr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  flag_stack_unit #(.DATA_WIDTH(16), .DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .aluResult(aluResult), .flagWrite(flagWrite),
    .push(push), .pop(pop), .clearErr(clearErr), .z(z), .n(n), .count(count),
    .full(full), .empty(empty), .overflowErr(overflowErr),
    .underflowErr(underflowErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fw;
    logic [15:0] alu;
    logic        ps;
    logic        pp;
    logic        clr;
    logic        ez;
    logic        en;
    logic [2:0]  ec;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic addv(input logic fw, input logic [15:0] alu, input logic ps,
                      input logic pp, input logic clr, input logic ez,
                      input logic en, input logic [2:0] ec, input logic eo,
                      input logic eu);
    vecs[nv] = {fw, alu, ps, pp, clr, ez, en, ec, eo, eu};
    nv++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ez, input logic en,
                         input logic [2:0] ec, input logic eo, input logic eu);
    chk({tag, ".z"}, int'(z), int'(ez));
    chk({tag, ".n"}, int'(n), int'(en));
    chk({tag, ".count"}, int'(count), int'(ec));
    chk({tag, ".full"}, int'(full), int'(ec == 3'd4));
    chk({tag, ".empty"}, int'(empty), int'(ec == 3'd0));
    chk({tag, ".ovf"}, int'(overflowErr), int'(eo));
    chk({tag, ".unf"}, int'(underflowErr), int'(eu));
  endtask

  task automatic drive(input logic fw, input logic [15:0] alu, input logic ps,
                       input logic pp, input logic clr);
    flagWrite = fw; aluResult = alu; push = ps; pop = pp; clearErr = clr;
  endtask

  initial begin
    //    fw alu       ps pp clr  z  n  cnt  ovf unf
    addv(1, 16'h0000, 0, 0, 0,   1, 0, 3'd0, 0, 0);  // zero result
    addv(1, 16'h8001, 0, 0, 0,   0, 1, 3'd0, 0, 0);  // negative result
    addv(0, 16'h0000, 0, 0, 0,   0, 1, 3'd0, 0, 0);  // hold
    addv(1, 16'h0000, 0, 0, 0,   1, 0, 3'd0, 0, 0);
    addv(0, 16'h0000, 1, 0, 0,   1, 0, 3'd1, 0, 0);  // push 10
    addv(1, 16'hFFFF, 0, 0, 0,   0, 1, 3'd1, 0, 0);
    addv(0, 16'h0000, 0, 1, 0,   1, 0, 3'd0, 0, 0);  // pop -> 10
    addv(1, 16'h0001, 0, 0, 0,   0, 0, 3'd0, 0, 0);
    addv(0, 16'h0000, 1, 0, 0,   0, 0, 3'd1, 0, 0);  // push 00
    addv(1, 16'h8000, 0, 0, 0,   0, 1, 3'd1, 0, 0);
    addv(0, 16'h0000, 1, 0, 0,   0, 1, 3'd2, 0, 0);  // push 01
    addv(1, 16'h0000, 0, 0, 0,   1, 0, 3'd2, 0, 0);
    addv(0, 16'h0000, 1, 0, 0,   1, 0, 3'd3, 0, 0);  // push 10
    addv(1, 16'h0002, 0, 0, 0,   0, 0, 3'd3, 0, 0);
    addv(0, 16'h0000, 1, 0, 0,   0, 0, 3'd4, 0, 0);  // push 00 -> full
    addv(0, 16'h0000, 1, 0, 0,   0, 0, 3'd4, 1, 0);  // overflow
    addv(1, 16'hFFFF, 0, 0, 0,   0, 1, 3'd4, 1, 0);
    addv(0, 16'h0000, 0, 1, 0,   0, 0, 3'd3, 1, 0);  // pop 00
    addv(0, 16'h0000, 0, 1, 0,   1, 0, 3'd2, 1, 0);  // pop 10
    addv(0, 16'h0000, 0, 1, 0,   0, 1, 3'd1, 1, 0);  // pop 01
    addv(0, 16'h0000, 0, 1, 0,   0, 0, 3'd0, 1, 0);  // pop 00
    addv(0, 16'h0000, 0, 0, 1,   0, 0, 3'd0, 0, 0);  // clear
    addv(1, 16'h0000, 0, 0, 0,   1, 0, 3'd0, 0, 0);
    addv(0, 16'h0000, 0, 1, 0,   1, 0, 3'd0, 0, 1);  // underflow
    addv(1, 16'h8000, 0, 1, 0,   0, 1, 3'd0, 0, 1);  // underflow, fw applies
    addv(0, 16'h0000, 1, 0, 0,   0, 1, 3'd1, 0, 1);  // push 01
    addv(1, 16'h0001, 0, 0, 0,   0, 0, 3'd1, 0, 1);
    addv(1, 16'h0000, 0, 1, 0,   0, 1, 3'd0, 0, 1);  // pop beats fw
    addv(0, 16'h0000, 1, 0, 0,   0, 1, 3'd1, 0, 1);  // push 01
    addv(1, 16'h0000, 1, 1, 0,   1, 0, 3'd1, 0, 1);  // push+pop, fw applies
    addv(0, 16'h0000, 0, 0, 1,   1, 0, 3'd1, 0, 0);  // clear
    addv(0, 16'h0000, 0, 1, 0,   0, 1, 3'd0, 0, 0);  // pop 01
    addv(0, 16'h0000, 0, 1, 1,   0, 1, 3'd0, 0, 1);  // event beats clear
    addv(0, 16'h0000, 0, 0, 1,   0, 1, 3'd0, 0, 0);
    addv(1, 16'h0000, 1, 0, 0,   1, 0, 3'd1, 0, 0);  // push old 01, fw new
    addv(0, 16'h0000, 0, 1, 0,   0, 1, 3'd0, 0, 0);  // pop -> 01

    drive(0, 16'h0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 3'd0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].fw, vecs[i].alu, vecs[i].ps, vecs[i].pp, vecs[i].clr);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].ez, vecs[i].en, vecs[i].ec,
              vecs[i].eo, vecs[i].eu);
      $display("vec%0d fw=%0b alu=%h push=%0b pop=%0b clr=%0b -> z=%0b n=%0b cnt=%0d ovf=%0b unf=%0b",
               i, vecs[i].fw, vecs[i].alu, vecs[i].ps, vecs[i].pp, vecs[i].clr,
               z, n, count, overflowErr, underflowErr);
    end

    // Async reset mid-sequence: reach count=3 with overflowErr set, flags 10.
    drive(1, 16'h0000, 0, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 1, 0, 0);
    repeat (5) @(negedge clk);
    chk_all("prefill", 1, 0, 3'd4, 1, 0);
    drive(0, 16'h0000, 0, 1, 0);
    @(negedge clk);
    drive(0, 16'h0000, 1, 0, 0);  // push pending when reset hits
    chk_all("prereset", 1, 0, 3'd3, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 0, 0, 3'd0, 0, 0);
    $display("async reset at t=%0t -> z=%0b n=%0b cnt=%0d ovf=%0b", $time,
             z, n, count, overflowErr);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 0);
    chk_all("reset_hold", 0, 0, 3'd0, 0, 0);
    rst_n = 1'b1;
    drive(1, 16'h8000, 0, 0, 0);
    @(negedge clk);
    chk_all("post_reset", 0, 1, 3'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
